// File: rtl/acc_bus_ctrl.sv
// acc_bus_ctrl: round-robin arbiter between an accelerator port and a host port in front of
// a single-port SRAM with fixed read latency. Define ACC_BUS_CTRL_STATS_EN for read/write counters.
module acc_bus_ctrl #(
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = 256,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  acc_valid,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    input  logic [DATA_WIDTH-1:0] acc_wdata,
    input  logic [STRB_WIDTH-1:0] acc_wstrb,
    output logic                  acc_ready,
    output logic [DATA_WIDTH-1:0] acc_rdata,
    output logic                  acc_rvalid,

    input  logic                  host_valid,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic [STRB_WIDTH-1:0] host_wstrb,
    output logic                  host_ready,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,

    output logic                  mem_en,
    output logic [STRB_WIDTH-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ACC_BUS_CTRL_STATS_EN
    ,
    output logic [31:0]           stat_rd_count,
    output logic [31:0]           stat_wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic       PORT_ACC  = 1'b0;
    localparam logic       PORT_HOST = 1'b1;
    localparam logic [2:0] LAT_LAST  = 3'(READ_LATENCY - 1);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  is_rd_q, is_rd_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  mem_en_q, mem_en_d;
    logic [STRB_WIDTH-1:0] mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] acc_rdata_q, acc_rdata_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  acc_rvalid_q, acc_rvalid_d;
    logic                  host_rvalid_q, host_rvalid_d;

    logic                  arb_open;
    logic                  pick_host;
    logic                  pick_acc;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_strb;

    // Arbitration is open in IDLE and in the RESP cycle; the port not served last wins a tie.
    always_comb begin
        arb_open  = (state_q == IDLE) || (state_q == RESP);
        pick_host = host_valid && (!acc_valid || (last_grant_q == PORT_ACC));
        pick_acc  = acc_valid && !pick_host;
        xfer      = arb_open && (pick_host || pick_acc);
        sel_addr  = pick_host ? host_addr  : acc_addr;
        sel_wdata = pick_host ? host_wdata : acc_wdata;
        sel_strb  = pick_host ? host_wstrb : acc_wstrb;
    end

    assign acc_ready  = arb_open && pick_acc;
    assign host_ready = arb_open && pick_host;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        is_rd_d       = is_rd_q;
        cnt_d         = cnt_q;
        mem_en_d      = 1'b0;
        mem_we_d      = '0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        acc_rdata_d   = acc_rdata_q;
        host_rdata_d  = host_rdata_q;
        acc_rvalid_d  = 1'b0;
        host_rvalid_d = 1'b0;

        case (state_q)
            IDLE, RESP: begin
                if (xfer) begin
                    // The mem_* registers double as the captured request.
                    state_d      = ISSUE;
                    last_grant_d = pick_host ? PORT_HOST : PORT_ACC;
                    owner_d      = pick_host ? PORT_HOST : PORT_ACC;
                    is_rd_d      = (sel_strb == '0);
                    mem_en_d     = 1'b1;
                    mem_we_d     = sel_strb;
                    mem_addr_d   = sel_addr;
                    mem_wdata_d  = sel_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (is_rd_q) begin
                    state_d = WAIT_RD;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_RD: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    if (owner_q == PORT_HOST) begin
                        host_rdata_d  = mem_rdata;
                        host_rvalid_d = 1'b1;
                    end else begin
                        acc_rdata_d  = mem_rdata;
                        acc_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= PORT_ACC;
            owner_q       <= PORT_ACC;
            is_rd_q       <= 1'b0;
            cnt_q         <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            acc_rdata_q   <= '0;
            host_rdata_q  <= '0;
            acc_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            is_rd_q       <= is_rd_d;
            cnt_q         <= cnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            acc_rdata_q   <= acc_rdata_d;
            host_rdata_q  <= host_rdata_d;
            acc_rvalid_q  <= acc_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign acc_rdata   = acc_rdata_q;
    assign acc_rvalid  = acc_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;

`ifdef ACC_BUS_CTRL_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d;
    logic [31:0] stat_wr_q, stat_wr_d;

    // Counted at acceptance; wrap-around is intentional.
    always_comb begin
        stat_rd_d = stat_rd_q;
        stat_wr_d = stat_wr_q;
        if (xfer) begin
            if (sel_strb == '0) begin
                stat_rd_d = stat_rd_q + 32'd1;
            end else begin
                stat_wr_d = stat_wr_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end

    assign stat_rd_count = stat_rd_q;
    assign stat_wr_count = stat_wr_q;
`endif

endmodule

// File: tb/tb_acc_bus_ctrl.sv
// Scoreboard bench for acc_bus_ctrl: main instance at READ_LATENCY=1, second at READ_LATENCY=4.
// Counter checks run when ACC_BUS_CTRL_STATS_EN is defined.
module tb_acc_bus_ctrl;
    localparam int AW = 19;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int RL = 1;

    typedef struct {
        logic          host;
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] we;
        logic [DW-1:0] wdata;
        int            cyc;
    } mem_exp_t;

    typedef struct {
        logic host;
        int   cyc;
    } hs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic          acc_valid = 1'b0, host_valid = 1'b0;
    logic [AW-1:0] acc_addr = '0, host_addr = '0;
    logic [DW-1:0] acc_wdata = '0, host_wdata = '0;
    logic [SW-1:0] acc_wstrb = '0, host_wstrb = '0;
    logic          acc_ready, host_ready, acc_rvalid, host_rvalid;
    logic [DW-1:0] acc_rdata, host_rdata;
    logic          mem_en;
    logic [SW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          a4_valid = 1'b0;
    logic [AW-1:0] a4_addr = '0;
    logic          a4_ready, a4_rvalid, h4_ready, h4_rvalid;
    logic [DW-1:0] a4_rdata, h4_rdata;
    logic          m4_en;
    logic [SW-1:0] m4_we;
    logic [AW-1:0] m4_addr;
    logic [DW-1:0] m4_wdata;
    logic [DW-1:0] m4_rdata;

`ifdef ACC_BUS_CTRL_STATS_EN
    logic [31:0] stat_rd_count, stat_wr_count, s4_rd, s4_wr;
`endif

    rd_exp_t       rd_q[$];
    mem_exp_t      mem_q[$];
    hs_t           hs_log[$];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] last_acc = '0;
    logic [DW-1:0] last_host = '0;

    acc_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst),
        .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_wstrb(acc_wstrb),
        .acc_ready(acc_ready), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
        .host_valid(host_valid), .host_addr(host_addr), .host_wdata(host_wdata), .host_wstrb(host_wstrb),
        .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ACC_BUS_CTRL_STATS_EN
        , .stat_rd_count(stat_rd_count), .stat_wr_count(stat_wr_count)
`endif
    );

    acc_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .READ_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .acc_valid(a4_valid), .acc_addr(a4_addr), .acc_wdata('0), .acc_wstrb('0),
        .acc_ready(a4_ready), .acc_rdata(a4_rdata), .acc_rvalid(a4_rvalid),
        .host_valid(1'b0), .host_addr('0), .host_wdata('0), .host_wstrb('0),
        .host_ready(h4_ready), .host_rdata(h4_rdata), .host_rvalid(h4_rvalid),
        .mem_en(m4_en), .mem_we(m4_we), .mem_addr(m4_addr), .mem_wdata(m4_wdata),
        .mem_rdata(m4_rdata)
`ifdef ACC_BUS_CTRL_STATS_EN
        , .stat_rd_count(s4_rd), .stat_wr_count(s4_wr)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model, latency 1: junk on the read port whenever no read was issued.
    logic [DW-1:0] sram [64];
    logic [DW-1:0] rd_pipe1;
    always @(posedge clk) begin
        if (mem_en && mem_we == '0) begin
            rd_pipe1 <= sram[mem_addr[5:0]];
        end else begin
            rd_pipe1 <= {8{32'hBAD0BAD0}};
        end
        if (mem_en) begin
            for (int b = 0; b < SW; b++) begin
                if (mem_we[b]) sram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end
    assign mem_rdata = rd_pipe1;

    function automatic logic [DW-1:0] pat4(input logic [AW-1:0] a);
        return {8{({13'd0, a} ^ 32'hC0DE0000)}};
    endfunction

    // Read-only SRAM model, latency 4.
    logic [DW-1:0] pipe4 [4];
    always @(posedge clk) begin
        pipe4[0] <= m4_en ? pat4(m4_addr) : {8{32'hBAD4BAD4}};
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
    end
    assign m4_rdata = pipe4[3];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic note_hs(input logic host, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
        mem_exp_t m;
        rd_exp_t  r;
        hs_t      h;
        m.addr = a; m.we = s; m.wdata = d; m.cyc = cyc + 1;
        mem_q.push_back(m);
        h.host = host; h.cyc = cyc;
        hs_log.push_back(h);
        if (s == '0) begin
            r.host = host; r.data = ref_mem[a[5:0]]; r.cyc = cyc + RL + 2;
            rd_q.push_back(r);
        end else begin
            for (int b = 0; b < SW; b++) begin
                if (s[b]) ref_mem[a[5:0]][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    task automatic monitor();
        rd_exp_t  r;
        mem_exp_t m;
        if (rst) return;
        if (acc_valid && acc_ready) note_hs(1'b0, acc_addr, acc_wdata, acc_wstrb);
        if (host_valid && host_ready) note_hs(1'b1, host_addr, host_wdata, host_wstrb);
        if (mem_en) begin
            chk("mem_en_expected", mem_q.size() != 0, 1);
            if (mem_q.size() != 0) begin
                m = mem_q.pop_front();
                chk("mem_cycle", cyc, m.cyc);
                chk("mem_addr", mem_addr, m.addr);
                chk("mem_we", mem_we, m.we);
                chk("mem_wdata", mem_wdata, m.wdata);
            end
        end
        if (acc_rvalid || host_rvalid) begin
            chk("rv_expected", rd_q.size() != 0, 1);
            chk("rv_onehot", acc_rvalid && host_rvalid, 0);
            if (rd_q.size() != 0) begin
                r = rd_q.pop_front();
                chk("rv_cycle", cyc, r.cyc);
                chk("rv_owner_host", host_rvalid, r.host);
                chk("rv_rdata", r.host ? host_rdata : acc_rdata, r.data);
                if (r.host) last_host = r.data;
                else last_acc = r.data;
            end
        end
        if (!acc_rvalid) chk("acc_rdata_hold", acc_rdata, last_acc);
        if (!host_rvalid) chk("host_rdata_hold", host_rdata, last_host);
    endtask

    always @(negedge clk) monitor();

    task automatic req(input logic host, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
        logic got;
        got = 1'b0;
        if (host) begin
            host_valid = 1'b1; host_addr = a; host_wdata = d; host_wstrb = s;
        end else begin
            acc_valid = 1'b1; acc_addr = a; acc_wdata = d; acc_wstrb = s;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = host ? host_ready : acc_ready;
        end
        chk(host ? "host_hs_timeout" : "acc_hs_timeout", got, 1);
        @(posedge clk); #1;
        if (host) host_valid = 1'b0;
        else acc_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd_q.size() != 0 || mem_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n < 100, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_q.delete();
        mem_q.delete();
        hs_log.delete();
        last_acc = '0;
        last_host = '0;
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acc_rvalid", acc_rvalid, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        chk("rst_acc_rdata", acc_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_acc_ready", acc_ready, 0);
        chk("rst_host_ready", host_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] pat;
        for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'h11 + 8'(i);

        @(posedge clk); #1;
        do_reset();

        // Host write then accelerator read of the same word.
        req(1'b1, 19'h00010, pat, '1);
        req(1'b0, 19'h00010, '0, '0);
        drain();
        chk("t1_acc_rdata", acc_rdata, pat);
        chk("t1_host_rdata_untouched", host_rdata, 0);

        // Partial write over an all-ones word.
        req(1'b1, 19'h00005, '1, '1);
        req(1'b0, 19'h00005, {224'd0, 32'hDEADBEEF}, 32'h0000000F);
        req(1'b1, 19'h00005, '0, '0);
        drain();
        chk("partial_rd", host_rdata, {{224{1'b1}}, 32'hDEADBEEF});

        // Back-to-back reads from one port.
        hs_log.delete();
        req(1'b0, 19'h00010, '0, '0);
        req(1'b0, 19'h00005, '0, '0);
        req(1'b0, 19'h00010, '0, '0);
        drain();
        chk("b2b_count", hs_log.size(), 3);
        for (int i = 1; i < hs_log.size(); i++) chk("b2b_gap", hs_log[i].cyc - hs_log[i-1].cyc, 3);

        // Both ports contending continuously straight after reset.
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) req(1'b1, 19'h00020 + 19'(i), {8{$urandom}}, '1);
            end
            begin
                for (int i = 0; i < 6; i++) req(1'b0, i[0] ? 19'h00005 : 19'h00010, '0, '0);
            end
        join
        drain();
        chk("arb_count", hs_log.size(), 12);
        if (hs_log.size() != 0) chk("arb_first_host", hs_log[0].host, 1);
        for (int i = 1; i < hs_log.size(); i++) chk("arb_alternate", hs_log[i].host != hs_log[i-1].host, 1);

        // Reset while a read waits on the SRAM.
        req(1'b0, 19'h00010, '0, '0);
        @(posedge clk); #1;
        do_reset();
        repeat (6) @(posedge clk);
        #1;
        req(1'b0, 19'h00005, '0, '0);
        drain();
        chk("post_rst_rdata", acc_rdata, {{224{1'b1}}, 32'hDEADBEEF});

        // READ_LATENCY=4 instance.
        a4_valid = 1'b1; a4_addr = 19'h00123;
        @(negedge clk);
        chk("rl4_ready", a4_ready, 1);
        @(posedge clk); #1;
        a4_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("rl4_mem_en", m4_en, k == 1);
            chk("rl4_rvalid", a4_rvalid, k == 6);
            if (k == 6) chk("rl4_rdata", a4_rdata, pat4(19'h00123));
            chk("rl4_host_rvalid", h4_rvalid, 0);
            @(posedge clk); #1;
        end

`ifdef ACC_BUS_CTRL_STATS_EN
        do_reset();
        chk("stat_rd_rst", stat_rd_count, 0);
        chk("stat_wr_rst", stat_wr_count, 0);
        req(1'b0, 19'h00010, '0, '0);
        req(1'b1, 19'h00030, '1, '1);
        req(1'b0, 19'h00005, '0, '0);
        req(1'b1, 19'h00031, '1, '1);
        req(1'b1, 19'h00010, '0, '0);
        drain();
        chk("stat_rd", stat_rd_count, 3);
        chk("stat_wr", stat_wr_count, 2);
        force dut.stat_wr_q = 32'hFFFFFFFF;
        @(posedge clk); #1;
        release dut.stat_wr_q;
        chk("stat_wr_preload", stat_wr_count, 32'hFFFFFFFF);
        req(1'b1, 19'h00032, '1, '1);
        drain();
        chk("stat_wr_wrap", stat_wr_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
